signed_div_16: RTL and testbench

Iterative signed Q8.8 fixed-point divider, the inverse of the team's combinational Q8.8 multiplier. It computes C = A / B with 8 integer bits and 8 fraction bits on all operands. It uses a restoring shift-subtract core, one quotient bit per cycle, and valid/ready handshakes on both sides. It sits in the datapath wherever a normalisation or reciprocal is needed and a single-cycle divider would be too large.

---
 rtl/fixed_pkg.sv | 34 +++
 rtl/q88_saturate.sv | 34 +++
 rtl/signed_div_16.sv | 172 +++++++++++++++++
 tb/tb_signed_div_16.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - shared Q8.8 fixed-point constants, divider state enum, helpers
//
// Purpose : common definitions for the Q8.8 arithmetic blocks (divider,
//           saturation helper and future Q8.8 units).
// Ports   : none (package).
package fixed_pkg;

  localparam int Q_WIDTH = 16;
  localparam int Q_FRAC  = 8;

  localparam logic [Q_WIDTH-1:0] Q_MAX = 16'h7FFF;
  localparam logic [Q_WIDTH-1:0] Q_MIN = 16'h8000;

  // Divider datapath widths: dividend magnitude is |A| << Q_FRAC, the partial
  // remainder needs one bit more than the divisor to hold the shifted value.
  localparam int DVD_W = Q_WIDTH + Q_FRAC;
  localparam int REM_W = Q_WIDTH + 1;
  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] CNT_LOAD = 5'd23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Unsigned magnitude of a two's complement Q8.8 value; 0x8000 maps to 32768.
  function automatic logic [Q_WIDTH-1:0] q_abs(input logic [Q_WIDTH-1:0] v);
    return v[Q_WIDTH-1] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/q88_saturate.sv
// rtl/q88_saturate.sv - sign/magnitude to Q8.8 conversion with overflow flag
//
// Purpose : turns a sign bit plus 24-bit magnitude into a 16-bit Q8.8 value
//           and flags results outside the representable range.
//           Build option SIGNED_DIV_16_SAT_EN: defined -> clamp to Q_MAX/Q_MIN
//           on overflow; undefined -> keep the low 16 bits (wraps).
// Ports   : sign  in  1   result is negative
//           mag   in  24  result magnitude
//           c     out 16  Q8.8 result
//           ovf   out 1   magnitude outside the Q8.8 range for this sign
module q88_saturate
  import fixed_pkg::*;
(
  input  logic               sign,
  input  logic [DVD_W-1:0]   mag,
  output logic [Q_WIDTH-1:0] c,
  output logic               ovf
);

  logic [Q_WIDTH-1:0] wrapped;

  always_comb begin
    // Low 16 bits of the two's complement of the full magnitude.
    wrapped = sign ? (~mag[Q_WIDTH-1:0] + 16'd1) : mag[Q_WIDTH-1:0];
    // Negative side reaches one further than positive (-32768 is legal).
    ovf     = sign ? (mag > 24'd32768) : (mag > 24'd32767);
`ifdef SIGNED_DIV_16_SAT_EN
    c       = ovf ? (sign ? Q_MIN : Q_MAX) : wrapped;
`else
    c       = wrapped;
`endif
  end

endmodule

// File: rtl/signed_div_16.sv
// rtl/signed_div_16.sv - iterative signed Q8.8 restoring divider, C = A / B
//
// Purpose : one quotient bit per cycle, sign/magnitude arithmetic, result
//           truncated toward zero. Build option SIGNED_DIV_16_SAT_EN selects
//           clamping (defined) or wrapping (undefined) on overflow.
// Ports   : clk        in  1   clock, rising edge
//           rst_n      in  1   asynchronous active-low reset
//           in_valid   in  1   A/B valid
//           in_ready   out 1   accepting operands (IDLE only)
//           A          in  16  signed Q8.8 dividend
//           B          in  16  signed Q8.8 divisor
//           out_valid  out 1   C/ovf/dbz valid (held until out_ready)
//           out_ready  in  1   consumer takes the result
//           C          out 16  signed Q8.8 quotient
//           ovf        out 1   quotient outside Q8.8 range
//           dbz        out 1   divisor was zero
module signed_div_16
  import fixed_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Q_WIDTH-1:0] A,
  input  logic [Q_WIDTH-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Q_WIDTH-1:0] C,
  output logic               ovf,
  output logic               dbz
);

  div_state_e         state_q, state_d;
  logic               sign_q, sign_d;
  logic [DVD_W-1:0]   dvd_q, dvd_d;
  logic [Q_WIDTH-1:0] dvs_q, dvs_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [DVD_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [Q_WIDTH-1:0] c_q, c_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;

  logic [Q_WIDTH-1:0] abs_a;
  logic [Q_WIDTH-1:0] abs_b;
  logic [Q_WIDTH-1:0] dbz_code;
  logic [REM_W:0]     rem_sh;
  logic               rem_ge;
  logic [REM_W-1:0]   rem_diff;
  logic [Q_WIDTH-1:0] sat_c;
  logic               sat_ovf;

  q88_saturate u_sat (
    .sign (sign_q),
    .mag  (quo_q),
    .c    (sat_c),
    .ovf  (sat_ovf)
  );

  always_comb begin
    abs_a = q_abs(A);
    abs_b = q_abs(B);

    // Divide-by-zero result follows the sign of the dividend.
    if (A == '0) begin
      dbz_code = '0;
    end else if (A[Q_WIDTH-1]) begin
      dbz_code = Q_MIN;
    end else begin
      dbz_code = Q_MAX;
    end

    // Bring down the next dividend bit, MSB first. The remainder is always
    // below the divisor, so the top bit of rem_sh is zero whenever rem_ge is
    // set and the 17-bit difference is exact.
    rem_sh   = {rem_q, dvd_q[cnt_q]};
    rem_ge   = rem_sh >= {2'b00, dvs_q};
    rem_diff = rem_sh[REM_W-1:0] - {1'b0, dvs_q};
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = A[Q_WIDTH-1] ^ B[Q_WIDTH-1];
          dvd_d  = {abs_a, {Q_FRAC{1'b0}}};
          dvs_d  = abs_b;
          rem_d  = '0;
          quo_d  = '0;
          if (B == '0) begin
            c_d     = dbz_code;
            ovf_d   = 1'b0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d = rem_ge ? rem_diff : rem_sh[REM_W-1:0];
        quo_d = {quo_q[DVD_W-2:0], rem_ge};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      FIX: begin
        c_d     = sat_c;
        ovf_d   = sat_ovf;
        dbz_d   = 1'b0;
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign C         = c_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_signed_div_16.sv
// tb/tb_signed_div_16.sv - self-checking bench for signed_div_16
module tb_signed_div_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] C;
  logic        ovf;
  logic        dbz;

  int checks = 0;
  int errors = 0;

`ifdef SIGNED_DIV_16_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  signed_div_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: real signed arithmetic on the Q8.8 integers.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] c, output logic o, output logic d);
    longint sa;
    longint sb;
    longint q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      d = 1'b1;
      o = 1'b0;
      c = (sa > 0) ? 16'h7FFF : ((sa < 0) ? 16'h8000 : 16'h0000);
    end else begin
      d = 1'b0;
      q = (sa * 256) / sb;
      o = (q > 32767) || (q < -32768);
      if (o && SAT) c = (q > 0) ? 16'h7FFF : 16'h8000;
      else          c = q[15:0];
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    A = a;
    B = b;
    chk("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", out_valid, 0);
    chk("in_ready_after_hs", in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] ec, input logic eo, input logic ed, input int elat);
    int lat;
    issue(a, b);
    wait_out(lat);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_C"}, C, ec);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_dbz"}, dbz, ed);
    handshake();
  endtask

  initial begin
    int          lat;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] ec;
    logic        eo;
    logic        ed;

    // Reset state
    #12;
    chk("rst_C", C, 16'h0000);
    chk("rst_ovf", ovf, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values
    run("d3_2",    16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25);
    run("dm3_2",   16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 25);
    run("d1_3",    16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25);
    run("ovf_pos", 16'h7F00, 16'h0080, SAT ? 16'h7FFF : 16'hFE00, 1'b1, 1'b0, 25);
    run("ovf_min", 16'h8000, 16'hFF00, SAT ? 16'h7FFF : 16'h8000, 1'b1, 1'b0, 25);
    run("dbz_neg", 16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1, 0);
    run("dbz_zero",16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 0);
    run("dbz_pos", 16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 0);

    // Back-pressure: hold result 10 cycles with a competing request pending
    issue(16'h0300, 16'h0200);
    wait_out(lat);
    chk("bp_latency", lat, 25);
    @(negedge clk);
    in_valid = 1'b1;
    A = 16'h0100;
    B = 16'h0300;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_C", C, 16'h0180);
      chk("bp_ovf", ovf, 0);
      chk("bp_dbz", dbz, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_hs_out_valid", out_valid, 0);
    chk("bp_hs_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accept_next", in_ready, 0);
    wait_out(lat);
    chk("bp_next_latency", lat, 25);
    chk("bp_next_C", C, 16'h0055);
    handshake();

    // Asynchronous reset in the middle of CALC
    issue(16'h0300, 16'h0200);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_C", C, 16'h0000);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_dbz", dbz, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 16'h0200, 16'h0100, 16'h0200, 1'b0, 1'b0, 25);

    // Randomized against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(1, 255));
        2:       rb = 16'hFFFF - 16'($urandom_range(0, 255));
        default: rb = 16'($urandom);
      endcase
      if (i == 0) rb = 16'h0001;
      model(ra, rb, ec, eo, ed);
      run("rnd", ra, rb, ec, eo, ed, (rb == 16'h0000) ? 0 : 25);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
